// File: rtl/nibble_serial_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial adder.
package nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit adder with carry-in; overflow is the unsigned carry-out.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built from one adder_4bit, one nibble per cycle, LSB nibble first.
// Optional signed_ovf output is enabled by defining NIBBLE_SERIAL_SIGNED_OVF_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | adding nibble idx, carry held in carry_reg
// DONE  | result held until out_ready
module nibble_serial_adder
  import nibble_serial_pkg::*;
#(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_a,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_b,
  input  logic                            carry_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum,
  output logic                            overflow,
  output logic                            busy
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
  ,
  output logic                            signed_ovf
`endif
);

  localparam int W     = NIBBLE_W * NUM_NIBBLES;
  localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;

  state_t             state, state_next;
  logic [W-1:0]       a_reg, b_reg, sum_reg;
  logic               carry_reg, ovf_reg;
  logic [IDX_W-1:0]   idx;
  logic               last;
  int                 nib_base;
  logic [NIBBLE_W-1:0] add_a, add_b, add_sum;
  logic               add_cout;

  assign last     = (idx == IDX_W'(NUM_NIBBLES - 1));
  assign nib_base = NIBBLE_W * int'(idx);
  assign add_a    = a_reg[nib_base +: NIBBLE_W];
  assign add_b    = b_reg[nib_base +: NIBBLE_W];

  adder_4bit u_adder (
    .a        (add_a),
    .b        (add_b),
    .carry_in (carry_reg),
    .sum      (add_sum),
    .overflow (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= carry_in;
            sum_reg   <= '0;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_reg[nib_base +: NIBBLE_W] <= add_sum;
          carry_reg <= add_cout;
          idx       <= idx + IDX_W'(1);
          if (last) ovf_reg <= add_cout;
        end
        default: ;
      endcase
    end
  end

`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
  // Top sum bit comes straight from the adder on the final nibble.
  logic sovf_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      sovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      sovf_reg <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[NIBBLE_W-1] != a_reg[W-1]);
    end
  end
  assign signed_ovf = sovf_reg;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NUM_NIBBLES=4): vector table, random ops, handshake corners.
// Signed-overflow checks are compiled in when NIBBLE_SERIAL_SIGNED_OVF_EN is defined.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         overflow;
  logic         busy;
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
  logic         signed_ovf;
`endif

  nibble_serial_adder #(.NUM_NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    ,
    .signed_ovf(signed_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         ovf;
    logic         sovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic model_sovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] es, input logic eo);
    exp_t e;
    check("in_ready_before_accept", in_ready, 1);
    op_a = a; op_b = b; carry_in = cin; in_valid = 1'b1;
    e.s = es; e.ovf = eo; e.sovf = model_sovf(a, b, cin);
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b;
    check("busy_in_run", {in_ready, busy, out_valid}, 3'b010);
  endtask

  // Wait for out_valid, compare against the scoreboard head; optionally release it at once.
  task automatic wait_result(input bit release_now);
    exp_t e;
    int   cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("latency", cyc, N);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("sum", sum, e.s);
    check("overflow", overflow, e.ovf);
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    check("signed_ovf", signed_ovf, e.sovf);
`endif
    if (release_now) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("ready_after_done", {in_ready, out_valid, busy}, 3'b100);
    end
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rs;
    logic [W-1:0] held_sum;
    logic         held_ovf;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0});
    vecs.push_back('{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
    vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0});

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("reset_sum", sum, 0);
    check("reset_ovf", overflow, 0);
`ifdef NIBBLE_SERIAL_SIGNED_OVF_EN
    check("reset_sovf", signed_ovf, 0);
`endif

    foreach (vecs[i]) begin
      drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_ovf);
      wait_result(1'b1);
    end

    for (int k = 0; k < 6; k++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(1));
      rs = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      drive_op(ra, rb, rc, rs[W-1:0], rs[W]);
      wait_result(1'b1);
    end

    // Back-pressure: result held while out_ready low, new operands ignored.
    drive_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    wait_result(1'b0);
    held_sum = sum; held_ovf = overflow;
    for (int k = 0; k < 3; k++) begin
      in_valid = (k == 1); op_a = 16'hAAAA; op_b = 16'hAAAA; carry_in = 1'b1;
      tick();
      check("bp_flags", {out_valid, in_ready, busy}, 3'b101);
      check("bp_sum", sum, 16'h5555);
      check("bp_ovf", overflow, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release", {in_ready, out_valid}, 2'b10);
    tick();
    check("bp_no_phantom", {in_ready, busy}, 2'b10);

    // Reset mid-RUN aborts with nothing left behind.
    drive_op(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("abort_flags", {in_ready, out_valid, busy}, 3'b100);
    check("abort_sum", sum, 0);
    check("abort_ovf", overflow, 0);
    tick();
    check("abort_idle", {in_ready, out_valid, busy}, 3'b100);
    drive_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
    wait_result(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-nibble serial adder that sits directly upstream of `adder_4bit` and drives it. It accepts a wide operand pair through a valid/ready handshake and presents one 4-bit slice per cycle to a single `adder_4bit` instance, least-significant nibble first. It registers each partial sum and the inter-nibble carry, then returns the full-width sum and carry-out through a second valid/ready handshake. This gives wide addition with one 4-bit adder, at a cost of NUM_NIBBLES cycles per operation.

## Interface
Parameters:
- NUM_NIBBLES, default 4: operand width in nibbles; W = 4*NUM_NIBBLES; legal range 1..16.

Ports (reset is synchronous, active-high):
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: op_a, op_b and carry_in are valid.
- in_ready, output, 1: block can accept; equals (state == IDLE).
- op_a, input, W: operand A (unsigned).
- op_b, input, W: operand B (unsigned).
- carry_in, input, 1: carry into nibble 0.
- out_valid, output, 1: sum and overflow are valid; equals (state == DONE).
- out_ready, input, 1: consumer takes the result.
- sum, output, W: registered result.
- overflow, output, 1: registered unsigned carry-out of the top nibble.
- busy, output, 1: equals (state != IDLE).

## Operation
- States:
  - IDLE: waits for in_valid && in_ready. On accept, captures op_a, op_b and carry_in into a carry register; clears sum; sets idx=0; goes to RUN.
  - RUN: feeds a_reg[4*idx+:4], b_reg[4*idx+:4] and the carry register to `adder_4bit`. On each edge:
    - writes the adder's sum into sum[4*idx+:4];
    - writes the adder's carry-out (its overflow port) into the carry register;
    - increments idx.
    - When idx == NUM_NIBBLES-1 on that edge, loads overflow from the carry-out and goes to DONE.
  - DONE: holds sum and overflow stable. When out_ready is high, goes to IDLE.
- Arithmetic: sum = (op_a + op_b + carry_in) mod 2^W; overflow = bit W of the same sum. No saturation.
- Operand registers are only written on accept. Changes on op_a/op_b after accept have no effect.
- in_valid in RUN or DONE is ignored; in_ready is 0 in those states.
- There is no back-to-back overlap. A new operation is accepted only in IDLE.
- Reset: a reset in any state, including mid-RUN, aborts the operation with no partial result.
  - Next state is IDLE.
  - sum=0, overflow=0, carry=0, idx=0, out_valid=0, busy=0; in_ready=1 from the first cycle after reset.
- NUM_NIBBLES=1: RUN lasts one cycle. The idx register is still present with width 1.

## Timing
- Accept edge T0: in_valid && in_ready sampled high.
- RUN occupies the cycles between edges T0..T(N), where N = NUM_NIBBLES.
- out_valid rises after edge T(N), so latency from accept to result is N cycles.
- If out_ready is high in the first DONE cycle, in_ready reasserts one cycle later.
- Minimum initiation interval: N+2 cycles.
- Back-pressure: out_valid, sum and overflow are held unchanged indefinitely while out_ready is low.
- Ripple path per cycle is one `adder_4bit` only. Adder inputs and outputs are registered at both ends.

## Configuration
- NIBBLE_SERIAL_SIGNED_OVF_EN defined:
  - Adds output port signed_ovf (1 bit), reset 0, registered with overflow when entering DONE.
  - signed_ovf = (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]), evaluated on the final nibble.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package nibble_serial_pkg holds:
  - NIBBLE_W = 4;
  - the state enum typedef {IDLE, RUN, DONE}.
- Single sub-module: one instance of the existing `adder_4bit`. No other hierarchy.
- Controller, datapath registers and handshake logic all live in nibble_serial_adder.

## Test plan
NUM_NIBBLES=4 unless stated.
- 0x1234 + 0x4321, cin=0 -> after 4 cycles out_valid=1, sum=0x5555, overflow=0.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, overflow=1. Carry propagates through all four nibbles.
- 0x0000 + 0x0000, cin=1 -> sum=0x0001, overflow=0. Then 0x0FFF + 0x0000, cin=1 -> sum=0x1000.
- Hold out_ready low for 3 cycles in DONE and pulse in_valid with new operands -> sum/overflow unchanged, in_ready=0, new operands ignored. After out_ready=1, in_ready=1 one cycle later.
- Assert rst after 2 RUN cycles of 0xAAAA + 0x5555 -> next cycle sum=0, overflow=0, out_valid=0, busy=0, in_ready=1. A fresh 0x0001 + 0x0001 then gives sum=0x0002.
- With NIBBLE_SERIAL_SIGNED_OVF_EN: 0x7FFF + 0x0001 -> sum=0x8000, signed_ovf=1, overflow=0. 0x8000 + 0x8000 -> sum=0x0000, signed_ovf=1, overflow=1.
